// File: rtl/router_output_channel.sv
// Router output channel: two virtual-channel FIFOs, polarity-selected pop.
// Optional pkt_count counter enabled by defining ROUTER_OC_PKT_COUNT_EN.
module router_output_channel #(
  parameter int DATA_WIDTH = 64,
  parameter int VC_DEPTH   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  polarity,
  input  logic                  wr_en,
  input  logic                  wr_vc,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  vc1_full,
  output logic                  vc2_full,
  input  logic                  ready,
  output logic                  send,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [15:0]           pkt_count
);

  localparam int AW = (VC_DEPTH > 1) ? $clog2(VC_DEPTH) : 1;
  localparam int CW = $clog2(VC_DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(VC_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [2][VC_DEPTH];
  logic [AW-1:0]         wp_q  [2];
  logic [AW-1:0]         wp_d  [2];
  logic [AW-1:0]         rp_q  [2];
  logic [AW-1:0]         rp_d  [2];
  logic [CW-1:0]         cnt_q [2];
  logic [CW-1:0]         cnt_d [2];
  logic [1:0]            full;
  logic [1:0]            push;
  logic [1:0]            pop;
  logic                  send_q;
  logic                  send_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] data_d;

  // Full is judged on start-of-cycle occupancy, so a pop never frees a slot
  // for a push in the same cycle.
  always_comb begin
    full = '0;
    push = '0;
    pop  = '0;
    for (int v = 0; v < 2; v++) begin
      full[v] = (cnt_q[v] == FULL_CNT);
      push[v] = wr_en && (wr_vc == 1'(v)) && !full[v];
      pop[v]  = ready && (polarity == 1'(v)) && (cnt_q[v] != '0);
    end
  end

  always_comb begin
    for (int v = 0; v < 2; v++) begin
      wp_d[v]  = wp_q[v] + AW'(push[v]);
      rp_d[v]  = rp_q[v] + AW'(pop[v]);
      cnt_d[v] = cnt_q[v] + CW'(push[v]) - CW'(pop[v]);
    end
    send_d = |pop;
    data_d = '0;
    if (pop[0]) begin
      data_d = mem_q[0][rp_q[0]];
    end else if (pop[1]) begin
      data_d = mem_q[1][rp_q[1]];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int v = 0; v < 2; v++) begin
        wp_q[v]  <= '0;
        rp_q[v]  <= '0;
        cnt_q[v] <= '0;
      end
      send_q <= 1'b0;
      data_q <= '0;
    end else begin
      for (int v = 0; v < 2; v++) begin
        wp_q[v]  <= wp_d[v];
        rp_q[v]  <= rp_d[v];
        cnt_q[v] <= cnt_d[v];
      end
      send_q <= send_d;
      data_q <= data_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int v = 0; v < 2; v++) begin
      if (push[v] && !reset) begin
        mem_q[v][wp_q[v]] <= wr_data;
      end
    end
  end

  assign vc1_full = full[0];
  assign vc2_full = full[1];
  assign send     = send_q;
  assign data_out = data_q;

`ifdef ROUTER_OC_PKT_COUNT_EN
  logic [15:0] pkt_q;
  logic [15:0] pkt_d;

  always_comb begin
    pkt_d = pkt_q;
    if (send_d) begin
      pkt_d = pkt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_q <= 16'h0000;
    end else begin
      pkt_q <= pkt_d;
    end
  end

  assign pkt_count = pkt_q;
`else
  assign pkt_count = 16'h0000;
`endif

endmodule
